// File: rtl/apu_sample_stream.sv
// APU output stage: decimates the per-clock sample, scales it by volume with saturation,
// and buffers the results in a first-word-fall-through FIFO drained by valid/ready.
module apu_sample_stream #(
  parameter int IN_WIDTH   = 9,
  parameter int OUT_WIDTH  = 8,
  parameter int DECIM      = 23,
  parameter int VOL_WIDTH  = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [IN_WIDTH-1:0]             i_sample,
  input  logic [VOL_WIDTH-1:0]            i_volume,
  input  logic                            i_mute,
  output logic [OUT_WIDTH-1:0]            o_sample,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [$clog2(FIFO_DEPTH):0]     o_level,
  output logic                            o_overflow,
  input  logic                            i_clear_overflow
);

  localparam int CNT_W  = $clog2(DECIM);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int PROD_W = IN_WIDTH + VOL_WIDTH + 1;
  localparam int SCL_W  = IN_WIDTH + 1;

  // Decimation counter
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  assign tick  = (cnt_q == CNT_W'(DECIM - 1));
  assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Stage 1: volume scaling and saturation of the point-sampled input
  logic [VOL_WIDTH:0]   gain;
  logic [PROD_W-1:0]    prod;
  logic [SCL_W-1:0]     scaled;
  logic [OUT_WIDTH-1:0] sat;
  logic [OUT_WIDTH-1:0] s1_sample_q, s1_sample_d;
  logic                 s1_valid_q, s1_valid_d;

  assign gain   = {1'b0, i_volume} + (VOL_WIDTH + 1)'(1);
  assign prod   = PROD_W'(i_sample) * PROD_W'(gain);
  assign scaled = SCL_W'(prod >> VOL_WIDTH);

  always_comb begin
    sat = scaled[OUT_WIDTH-1:0];
    if (|scaled[SCL_W-1:OUT_WIDTH]) begin
      sat = '1;
    end
    if (i_mute) begin
      sat = '0;
    end
  end

  always_comb begin
    s1_valid_d  = tick;
    s1_sample_d = s1_sample_q;
    if (tick) begin
      s1_sample_d = sat;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sample_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sample_q <= s1_sample_d;
    end
  end

  // Stage 2: output FIFO
  logic [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 ovf_q, ovf_d;
  logic                 full, empty, push, pop, drop;

  assign full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty = (level_q == '0);
  assign pop   = !empty && i_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push  = s1_valid_q && (!full || pop);
  assign drop  = s1_valid_q && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (drop) begin
      ovf_d = 1'b1;
    end else if (i_clear_overflow) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage carries no reset; stale entries are never visible because o_sample is gated by empty.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s1_sample_q;
    end
  end

  assign o_valid    = !empty;
  assign o_sample   = empty ? '0 : mem_q[rd_ptr_q];
  assign o_level    = level_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_apu_sample_stream.sv
// Self-checking bench for apu_sample_stream: table-driven vectors, hand-written corner
// sequences and randomized traffic, all compared every cycle against a queue-based model.
module tb_apu_sample_stream;

  localparam int INW   = 9;
  localparam int OUTW  = 8;
  localparam int VOLW  = 4;
  localparam int DEC   = 4;
  localparam int DEPTH = 4;
  localparam int LVLW  = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [INW-1:0]  i_sample = '0;
  logic [VOLW-1:0] i_volume = '0;
  logic            i_mute = 1'b0;
  logic [OUTW-1:0] o_sample;
  logic            o_valid;
  logic            i_ready = 1'b0;
  logic [LVLW-1:0] o_level;
  logic            o_overflow;
  logic            i_clear_overflow = 1'b0;

  always #5 clk = ~clk;

  apu_sample_stream #(
    .IN_WIDTH(INW), .OUT_WIDTH(OUTW), .DECIM(DEC), .VOL_WIDTH(VOLW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample(i_sample), .i_volume(i_volume), .i_mute(i_mute),
    .o_sample(o_sample), .o_valid(o_valid), .i_ready(i_ready), .o_level(o_level),
    .o_overflow(o_overflow), .i_clear_overflow(i_clear_overflow)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state: cycles since reset release, sample awaiting FIFO write, FIFO queue.
  int cyc = 0;
  bit pend_v = 0;
  int pend_val = 0;
  int q[$];
  bit m_ovf = 0;
  bit ramp = 0;

  typedef struct {
    int sample;
    int vol;
    bit mute;
    int exp;
  } vec_t;
  vec_t vecs[9];

  function automatic int ref_sat(int s, int v, bit m);
    int r;
    r = (s * (v + 1)) / (1 << VOLW);
    if (m) return 0;
    if (r > (1 << OUTW) - 1) return (1 << OUTW) - 1;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pend_v = 0;
    pend_val = 0;
    m_ovf = 0;
    cyc = 0;
  endtask

  task automatic model_edge();
    bit drop;
    drop = 0;
    if (q.size() > 0 && i_ready) void'(q.pop_front());
    if (pend_v) begin
      if (q.size() < DEPTH) q.push_back(pend_val);
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (i_clear_overflow) m_ovf = 0;
    pend_v = ((cyc % DEC) == DEC - 1);
    pend_val = ref_sat(int'(i_sample), int'(i_volume), i_mute);
    cyc++;
  endtask

  task automatic compare_all();
    chk("model_valid", o_valid, q.size() > 0);
    chk("model_sample", o_sample, (q.size() > 0) ? q[0] : 0);
    chk("model_level", o_level, q.size());
    chk("model_overflow", o_overflow, m_ovf);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    @(negedge clk);
    compare_all();
    if (ramp) i_sample = INW'(20 + cyc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_clear_overflow = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    model_reset();
  endtask

  // Expect a valid pulse at cycle 5 and again at cycle 9, low in between (ready held at 1).
  task automatic check_cadence(int idx, int exp);
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 4) chk("first_valid_early", o_valid, 1'b0);
      if (k == 5) begin
        chk("first_valid_c5", o_valid, 1'b1);
        chk("vec_sample", o_sample, exp);
        $display("vec %0d sample=%0d vol=%0d mute=%0d out=%0d exp=%0d",
                 idx, i_sample, i_volume, i_mute, o_sample, exp);
      end
      if (k >= 6 && k <= 8) chk("pulse_gap", o_valid, 1'b0);
      if (k == 9) chk("pulse_c9", o_valid, 1'b1);
    end
  endtask

  initial begin
    vecs[0] = '{100, 15, 0, 100};
    vecs[1] = '{400, 15, 0, 255};
    vecs[2] = '{400,  7, 0, 200};
    vecs[3] = '{511,  0, 0,  31};
    vecs[4] = '{300, 15, 1,   0};
    vecs[5] = '{255, 15, 0, 255};
    vecs[6] = '{256, 15, 0, 255};
    vecs[7] = '{  0, 15, 0,   0};
    vecs[8] = '{511, 15, 0, 255};

    // Reset state
    @(negedge clk);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_sample", o_sample, 0);
    chk("rst_level", o_level, 0);
    chk("rst_overflow", o_overflow, 1'b0);

    // Table-driven vectors
    foreach (vecs[i]) begin
      do_reset();
      i_sample = INW'(vecs[i].sample);
      i_volume = VOLW'(vecs[i].vol);
      i_mute   = vecs[i].mute;
      i_ready  = 1'b1;
      check_cadence(i, vecs[i].exp);
    end

    // Mute then un-mute: rate preserved, next tick after un-mute is full scale
    do_reset();
    i_sample = INW'(300); i_volume = VOLW'(15); i_mute = 1'b1; i_ready = 1'b1;
    for (int k = 1; k <= 9; k++) step();
    chk("mute_valid", o_valid, 1'b1);
    chk("mute_sample", o_sample, 0);
    i_mute = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("unmute_valid", o_valid, 1'b1);
    chk("unmute_sample", o_sample, 255);
    $display("unmute out=%0d", o_sample);

    // Back-pressure for 6 ticks: 4 stored, 2 dropped, then drain in order and clear flag
    do_reset();
    i_volume = VOLW'(15); i_mute = 1'b0; i_ready = 1'b0; ramp = 1;
    i_sample = INW'(20);
    for (int k = 1; k <= 25; k++) step();
    chk("bp_level_full", o_level, DEPTH);
    chk("bp_overflow_set", o_overflow, 1'b1);
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_drain_order", o_sample, 23 + 4 * k);
      $display("drain pop sample=%0d", o_sample);
      step();
    end
    chk("bp_overflow_sticky", o_overflow, 1'b1);
    i_clear_overflow = 1'b1;
    step();
    i_clear_overflow = 1'b0;
    chk("bp_overflow_cleared", o_overflow, 1'b0);

    // Full FIFO with pop and push in the same cycle
    do_reset();
    i_ready = 1'b0; ramp = 1; i_sample = INW'(20);
    begin
      bit found;
      found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
        step();
        if (q.size() == DEPTH && pend_v) found = 1;
      end
      chk("fullpop_reached", found, 1'b1);
    end
    i_ready = 1'b1;
    step();
    chk("fullpop_level", o_level, DEPTH);
    chk("fullpop_overflow", o_overflow, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("fullpop_order", o_sample, 27 + 4 * k);
      $display("fullpop pop sample=%0d", o_sample);
      step();
    end

    // Asynchronous reset mid-stream with 3 entries buffered
    do_reset();
    i_ready = 1'b0; ramp = 1; i_sample = INW'(20);
    begin
      bit found;
      found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
        step();
        if (q.size() == 3) found = 1;
      end
      chk("midrst_level3", o_level, 3);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", o_valid, 1'b0);
    chk("midrst_sample", o_sample, 0);
    chk("midrst_level", o_level, 0);
    chk("midrst_overflow", o_overflow, 1'b0);
    $display("mid-stream reset level=%0d valid=%0d", o_level, o_valid);
    model_reset();
    step();
    ramp = 0;
    rst_n = 1'b1;
    model_reset();
    i_sample = INW'(100); i_volume = VOLW'(15); i_ready = 1'b1;
    check_cadence(99, 100);

    // Randomized traffic against the model
    do_reset();
    for (int blk = 0; blk < 12; blk++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(0, 100);
      for (int k = 0; k < 200; k++) begin
        i_sample = INW'($urandom_range(0, (1 << INW) - 1));
        i_volume = VOLW'($urandom_range(0, (1 << VOLW) - 1));
        i_mute = ($urandom_range(0, 7) == 0);
        i_ready = ($urandom_range(0, 99) < rdy_pct);
        i_clear_overflow = ($urandom_range(0, 15) == 0);
        step();
      end
      $display("random block %0d ready_pct=%0d level=%0d overflow=%0d",
               blk, rdy_pct, o_level, o_overflow);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
